seg_time_reader: RTL and testbench

Display-side reader for the alarm-clock datapath. It samples the eight 7-segment digit buses and the buzzer line driven by the clock core, and decodes them back to binary time-of-day and day-of-week. On every sample it checks that the time advanced by exactly one second, and it counts segment faults, step faults and buzzer-active samples. It sits beside the clock core in simulation and bring-up as a self-checking monitor, the receiving end of the segment interface the core drives.

---
 rtl/seg_time_reader_if.sv | 25 ++
 rtl/seg_time_reader.sv | 217 +++++++++++++++++++++
 tb/tb_seg_time_reader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg_time_reader_if.sv
// Segment-display bus between the alarm-clock core (master) and a reader (slave).
// Carries the sample strobe, check enable, eight digit patterns and the buzzer line.
interface seg_time_reader_if;
   logic       sample;
   logic       check_en;
   logic       buzz;
   logic [6:0] h1disp;
   logic [6:0] h0disp;
   logic [6:0] m1disp;
   logic [6:0] m0disp;
   logic [6:0] s1disp;
   logic [6:0] s0disp;
   logic [6:0] d1disp;
   logic [6:0] d0disp;

   modport master (
      output sample, check_en, buzz,
      output h1disp, h0disp, m1disp, m0disp, s1disp, s0disp, d1disp, d0disp
   );

   modport slave (
      input sample, check_en, buzz,
      input h1disp, h0disp, m1disp, m0disp, s1disp, s0disp, d1disp, d0disp
   );
endinterface

// File: rtl/seg_time_reader.sv
// Decodes the clock core's 7-segment buses back to binary time-of-day and checks
// that consecutive samples advance by exactly one second, counting faults and buzzer hits.
module seg_time_reader #(
   parameter int NS = 60,
   parameter int NH = 24,
   parameter int ND = 7
) (
   input  logic                i_clk,
   input  logic                i_reset,
   seg_time_reader_if.slave    i_seg,
   output logic [4:0]          o_hrs,
   output logic [5:0]          o_mins,
   output logic [5:0]          o_secs,
   output logic [2:0]          o_day,
   output logic                o_valid,
   output logic                o_step_ok,
   output logic                o_step_err,
   output logic                o_seg_err,
   output logic [7:0]          o_err_cnt,
   output logic [15:0]         o_buzz_cnt
);

   typedef enum logic {ST_IDLE = 1'b0, ST_TRACK = 1'b1} state_t;

   localparam logic [5:0] LP_S_MAX = 6'(NS - 1);
   localparam logic [4:0] LP_H_MAX = 5'(NH - 1);
   localparam logic [2:0] LP_D_MAX = 3'(ND - 1);

   // Returns {legal, digit}; {g,f,e,d,c,b,a} active-high encoding.
   function automatic logic [4:0] f_seg_dec(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'h3F:   r = {1'b1, 4'd0};
         7'h06:   r = {1'b1, 4'd1};
         7'h5B:   r = {1'b1, 4'd2};
         7'h4F:   r = {1'b1, 4'd3};
         7'h66:   r = {1'b1, 4'd4};
         7'h6D:   r = {1'b1, 4'd5};
         7'h7D:   r = {1'b1, 4'd6};
         7'h07:   r = {1'b1, 4'd7};
         7'h7F:   r = {1'b1, 4'd8};
         7'h6F:   r = {1'b1, 4'd9};
         default: r = {1'b0, 4'd0};
      endcase
      return r;
   endfunction

   logic [4:0] w_h1, w_h0, w_m1, w_m0, w_s1, w_s0, w_d1, w_d0;
   logic [6:0] w_hrs_v, w_mins_v, w_secs_v;
   logic       w_digits_ok, w_legal, w_step_match;
   logic [5:0] w_inc_secs, w_inc_mins;
   logic [4:0] w_inc_hrs;
   logic [2:0] w_inc_day;

   state_t     r_state, w_state_nxt;
   logic       w_load, w_valid_nxt, w_ok_nxt, w_err_nxt, w_seg_nxt, w_err_inc;

   logic [4:0]  r_hrs;
   logic [5:0]  r_mins, r_secs;
   logic [2:0]  r_day;
   logic        r_valid, r_step_ok, r_step_err, r_seg_err;
   logic [7:0]  r_err_cnt;
   logic [15:0] r_buzz_cnt;

   assign w_h1 = f_seg_dec(i_seg.h1disp);
   assign w_h0 = f_seg_dec(i_seg.h0disp);
   assign w_m1 = f_seg_dec(i_seg.m1disp);
   assign w_m0 = f_seg_dec(i_seg.m0disp);
   assign w_s1 = f_seg_dec(i_seg.s1disp);
   assign w_s0 = f_seg_dec(i_seg.s0disp);
   assign w_d1 = f_seg_dec(i_seg.d1disp);
   assign w_d0 = f_seg_dec(i_seg.d0disp);

   assign w_hrs_v  = 7'(w_h1[3:0]) * 7'd10 + 7'(w_h0[3:0]);
   assign w_mins_v = 7'(w_m1[3:0]) * 7'd10 + 7'(w_m0[3:0]);
   assign w_secs_v = 7'(w_s1[3:0]) * 7'd10 + 7'(w_s0[3:0]);

   assign w_digits_ok = w_h1[4] & w_h0[4] & w_m1[4] & w_m0[4] &
                        w_s1[4] & w_s0[4] & w_d1[4] & w_d0[4];
   assign w_legal = w_digits_ok && (w_secs_v < 7'(NS)) && (w_mins_v < 7'(NS)) &&
                    (w_hrs_v < 7'(NH)) && (w_d0[3:0] < 4'(ND)) && (w_d1[3:0] == 4'd0);

   // Stored time advanced by one second, with cascaded wrap/carry.
   always_comb begin
      w_inc_secs = r_secs + 6'd1;
      w_inc_mins = r_mins;
      w_inc_hrs  = r_hrs;
      w_inc_day  = r_day;
      if (r_secs == LP_S_MAX) begin
         w_inc_secs = 6'd0;
         w_inc_mins = r_mins + 6'd1;
         if (r_mins == LP_S_MAX) begin
            w_inc_mins = 6'd0;
            w_inc_hrs  = r_hrs + 5'd1;
            if (r_hrs == LP_H_MAX) begin
               w_inc_hrs = 5'd0;
               if (r_day == LP_D_MAX) begin
                  w_inc_day = 3'd0;
               end else begin
                  w_inc_day = r_day + 3'd1;
               end
            end else begin
               w_inc_day = r_day;
            end
         end else begin
            w_inc_hrs = r_hrs;
         end
      end else begin
         w_inc_mins = r_mins;
      end
   end

   assign w_step_match = (w_secs_v[5:0] == w_inc_secs) && (w_mins_v[5:0] == w_inc_mins) &&
                         (w_hrs_v[4:0] == w_inc_hrs) && (w_d0[2:0] == w_inc_day);

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: only a legal, checked sample holds a baseline.
   always_comb begin
      w_state_nxt = r_state;
      if (i_seg.sample) begin
         if (w_legal && i_seg.check_en) begin
            w_state_nxt = ST_TRACK;
         end else begin
            w_state_nxt = ST_IDLE;
         end
      end else begin
         w_state_nxt = r_state;
      end
   end

   // Output decisions for the current sample.
   always_comb begin
      w_load      = 1'b0;
      w_valid_nxt = r_valid;
      w_ok_nxt    = 1'b0;
      w_err_nxt   = 1'b0;
      w_seg_nxt   = 1'b0;
      if (i_seg.sample) begin
         if (!w_legal) begin
            w_seg_nxt   = 1'b1;
            w_valid_nxt = 1'b0;
         end else begin
            w_load      = 1'b1;
            w_valid_nxt = 1'b1;
            case (r_state)
               ST_TRACK: begin
                  if (i_seg.check_en) begin
                     w_ok_nxt  = w_step_match;
                     w_err_nxt = ~w_step_match;
                  end else begin
                     w_ok_nxt  = 1'b0;
                  end
               end
               ST_IDLE:  w_ok_nxt = 1'b0;
               default:  w_ok_nxt = 1'b0;
            endcase
         end
      end else begin
         w_load = 1'b0;
      end
   end

   assign w_err_inc = w_seg_nxt | w_err_nxt;

   // Registered outputs, pulses and saturating counters.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_hrs      <= 5'd0;
         r_mins     <= 6'd0;
         r_secs     <= 6'd0;
         r_day      <= 3'd0;
         r_valid    <= 1'b0;
         r_step_ok  <= 1'b0;
         r_step_err <= 1'b0;
         r_seg_err  <= 1'b0;
         r_err_cnt  <= 8'd0;
         r_buzz_cnt <= 16'd0;
      end else begin
         if (w_load) begin
            r_hrs  <= w_hrs_v[4:0];
            r_mins <= w_mins_v[5:0];
            r_secs <= w_secs_v[5:0];
            r_day  <= w_d0[2:0];
         end
         r_valid    <= w_valid_nxt;
         r_step_ok  <= w_ok_nxt;
         r_step_err <= w_err_nxt;
         r_seg_err  <= w_seg_nxt;
         if (w_err_inc && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
         if (i_seg.sample && i_seg.buzz && (r_buzz_cnt != 16'hFFFF)) begin
            r_buzz_cnt <= r_buzz_cnt + 16'd1;
         end
      end
   end

   assign o_hrs      = r_hrs;
   assign o_mins     = r_mins;
   assign o_secs     = r_secs;
   assign o_day      = r_day;
   assign o_valid    = r_valid;
   assign o_step_ok  = r_step_ok;
   assign o_step_err = r_step_err;
   assign o_seg_err  = r_seg_err;
   assign o_err_cnt  = r_err_cnt;
   assign o_buzz_cnt = r_buzz_cnt;

endmodule

// File: tb/tb_seg_time_reader.sv
// Randomized scoreboard bench for seg_time_reader; the reference model tracks time
// as seconds-into-week and judges steps with modular arithmetic.
module tb_seg_time_reader;
   localparam int WEEK = 7 * 86400;

   typedef struct packed {
      logic [4:0]  hrs;
      logic [5:0]  mins;
      logic [5:0]  secs;
      logic [2:0]  day;
      logic        valid;
      logic        ok;
      logic        err;
      logic        seg;
      logic [7:0]  errcnt;
      logic [15:0] buzzcnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seg_time_reader_if u_if ();

   logic [4:0]  o_hrs;
   logic [5:0]  o_mins, o_secs;
   logic [2:0]  o_day;
   logic        o_valid, o_step_ok, o_step_err, o_seg_err;
   logic [7:0]  o_err_cnt;
   logic [15:0] o_buzz_cnt;

   seg_time_reader u_dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_seg      (u_if),
      .o_hrs      (o_hrs),
      .o_mins     (o_mins),
      .o_secs     (o_secs),
      .o_day      (o_day),
      .o_valid    (o_valid),
      .o_step_ok  (o_step_ok),
      .o_step_err (o_step_err),
      .o_seg_err  (o_seg_err),
      .o_err_cnt  (o_err_cnt),
      .o_buzz_cnt (o_buzz_cnt)
   );

   logic [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   int total = 0;
   int bad   = 0;
   exp_t q[$];

   // Reference model state
   int m_hrs = 0, m_mins = 0, m_secs = 0, m_day = 0, m_tot = 0, m_err = 0, m_buzz = 0;
   bit m_valid = 0, m_base = 0;
   int cur = 0;

   function automatic int dec(input logic [6:0] p);
      int v = -1;
      for (int k = 0; k < 10; k++) if (pats[k] == p) v = k;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_tot(input int t);
      int d, h, m, s;
      d = t / 86400; h = (t / 3600) % 24; m = (t / 60) % 60; s = t % 60;
      u_if.h1disp = pats[h / 10]; u_if.h0disp = pats[h % 10];
      u_if.m1disp = pats[m / 10]; u_if.m0disp = pats[m % 10];
      u_if.s1disp = pats[s / 10]; u_if.s0disp = pats[s % 10];
      u_if.d1disp = pats[0];      u_if.d0disp = pats[d];
   endtask

   task automatic model_sample();
      int v[8];
      bit legal, ok, er, sg;
      int h, m, s, d, t;
      exp_t e;
      v[0] = dec(u_if.h1disp); v[1] = dec(u_if.h0disp);
      v[2] = dec(u_if.m1disp); v[3] = dec(u_if.m0disp);
      v[4] = dec(u_if.s1disp); v[5] = dec(u_if.s0disp);
      v[6] = dec(u_if.d1disp); v[7] = dec(u_if.d0disp);
      legal = 1;
      for (int k = 0; k < 8; k++) if (v[k] < 0) legal = 0;
      h = v[0] * 10 + v[1]; m = v[2] * 10 + v[3]; s = v[4] * 10 + v[5]; d = v[7];
      if (legal && !(s < 60 && m < 60 && h < 24 && d < 7 && v[6] == 0)) legal = 0;
      ok = 0; er = 0; sg = 0;
      if (!legal) begin
         sg = 1; m_valid = 0; m_base = 0;
      end else begin
         t = d * 86400 + h * 3600 + m * 60 + s;
         if (u_if.check_en && m_base) begin
            if (t == (m_tot + 1) % WEEK) ok = 1; else er = 1;
         end
         m_base = u_if.check_en; m_tot = t; m_valid = 1;
         m_hrs = h; m_mins = m; m_secs = s; m_day = d;
      end
      if ((sg || er) && m_err < 255) m_err++;
      if (u_if.buzz && m_buzz < 65535) m_buzz++;
      e.hrs = 5'(m_hrs); e.mins = 6'(m_mins); e.secs = 6'(m_secs); e.day = 3'(m_day);
      e.valid = m_valid; e.ok = ok; e.err = er; e.seg = sg;
      e.errcnt = 8'(m_err); e.buzzcnt = 16'(m_buzz);
      q.push_back(e);
   endtask

   // One clock of stimulus: model updated and expectation queued before the edge.
   task automatic step(input bit r, input bit smp);
      exp_t e;
      rst = r; u_if.sample = smp;
      if (r) begin
         m_hrs = 0; m_mins = 0; m_secs = 0; m_day = 0; m_err = 0; m_buzz = 0;
         m_valid = 0; m_base = 0;
         e = '0;
         q.push_back(e);
      end else if (smp) begin
         model_sample();
      end
      @(posedge clk); #1;
      rst = 1'b0; u_if.sample = 1'b0;
   endtask

   task automatic samp_time(input int t);
      cur = t; set_tot(t); step(1'b0, 1'b1);
   endtask

   // Monitor: compares outputs half a cycle after each edge that consumed a sample or reset.
   always begin
      bit pend;
      exp_t e;
      @(posedge clk);
      pend = rst || u_if.sample;
      @(negedge clk);
      if (pend) begin
         if (q.size() == 0) begin
            check("queue_underflow", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            check("hrs", 32'(o_hrs), 32'(e.hrs));
            check("mins", 32'(o_mins), 32'(e.mins));
            check("secs", 32'(o_secs), 32'(e.secs));
            check("day", 32'(o_day), 32'(e.day));
            check("valid", 32'(o_valid), 32'(e.valid));
            check("step_ok", 32'(o_step_ok), 32'(e.ok));
            check("step_err", 32'(o_step_err), 32'(e.err));
            check("seg_err", 32'(o_seg_err), 32'(e.seg));
            check("err_cnt", 32'(o_err_cnt), 32'(e.errcnt));
            check("buzz_cnt", 32'(o_buzz_cnt), 32'(e.buzzcnt));
         end
      end else begin
         check("idle_pulses", 32'({o_step_ok, o_step_err, o_seg_err}), 32'd0);
      end
   end

   initial begin
      int r, k;
      rst = 1'b1;
      u_if.sample = 1'b0; u_if.check_en = 1'b1; u_if.buzz = 1'b0;
      set_tot(0);
      step(1'b1, 1'b0); step(1'b1, 1'b0);
      step(1'b0, 1'b0); step(1'b0, 1'b0);

      // Baseline, then legal steps with minute carry
      samp_time(58); samp_time(59); samp_time(60);
      // Week wrap
      samp_time(6 * 86400 + 86399); samp_time(0);
      // Skipped second, then recovery
      samp_time(36000); samp_time(36002); samp_time(36003);
      // Illegal pattern, baseline after fault, out-of-range minutes
      set_tot(36004); u_if.s0disp = 7'h01; step(1'b0, 1'b1);
      samp_time(36005);
      set_tot(36006); u_if.m1disp = 7'h7D; step(1'b0, 1'b1);
      // Equal time counts as error
      samp_time(36007); samp_time(36007);
      // Decode-only jumps
      u_if.check_en = 1'b0;
      samp_time(43200); samp_time(27000);
      u_if.check_en = 1'b1;
      // Buzzer on five samples
      u_if.buzz = 1'b1;
      for (int i = 0; i < 5; i++) samp_time(27001 + i);
      u_if.buzz = 1'b0;
      // Reset together with a sample: reset wins
      samp_time(27006);
      set_tot(27007); step(1'b1, 1'b1);
      samp_time(27008); samp_time(27009);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         u_if.check_en = ($urandom % 10) != 0;
         u_if.buzz     = ($urandom % 4) == 0;
         r = $urandom % 100;
         if (r < 55) begin
            samp_time((cur + 1) % WEEK);
         end else if (r < 65) begin
            samp_time($urandom % WEEK);
         end else if (r < 68) begin
            samp_time(cur);
         end else if (r < 82) begin
            set_tot(cur);
            k = $urandom % 6;
            case (k)
               0: u_if.m1disp = pats[6 + ($urandom % 4)];
               1: begin u_if.h1disp = pats[2]; u_if.h0disp = pats[4 + ($urandom % 6)]; end
               2: u_if.d1disp = pats[1 + ($urandom % 9)];
               3: u_if.d0disp = pats[7 + ($urandom % 3)];
               4: u_if.s1disp = pats[6 + ($urandom % 4)];
               default: u_if.h0disp = 7'($urandom);
            endcase
            step(1'b0, 1'b1);
         end else if (r < 99) begin
            step(1'b0, 1'b0);
         end else begin
            set_tot(cur); step(1'b1, ($urandom % 2) == 1);
         end
      end

      step(1'b0, 1'b0); step(1'b0, 1'b0);
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
